// File: rtl/cordic_pkg.sv
// Shared types for the CORDIC request scheduler.
// Q4.12 fixed-point format and scheduler state encoding.
package cordic_pkg;
  localparam int SIZE = 16;
  localparam int INT  = 4;
  localparam int FRAC = 12;

  typedef logic signed [SIZE-1:0] fix_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_e;
endpackage

// File: rtl/cordic_rr_sched_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping.
// Purely combinational; one-hot grant plus binary index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);
  int w_j;

  // Walk from farthest to nearest so the nearest hit wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = int'(i_ptr) + k;
      if (w_j >= NREQ) w_j = w_j - NREQ;
      if (i_req[w_j]) begin
        o_grant      = '0;
        o_grant[w_j] = 1'b1;
        o_idx        = IW'(w_j);
      end
    end
    o_any = |i_req;
  end
endmodule

// File: rtl/cordic_rr_sched.sv
// Round-robin scheduler sharing one rot_cordic engine among NREQ lanes.
// CORDIC_TIMEOUT_EN adds a WAIT watchdog that aborts with rsp_err.
module cordic_rr_sched #(
  parameter int NREQ    = 4,
  parameter int SIZE    = cordic_pkg::SIZE,
  parameter int TIMEOUT = 64,
  parameter int IW      = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*SIZE-1:0] req_x,
  input  logic [NREQ*SIZE-1:0] req_y,
  input  logic [NREQ*SIZE-1:0] req_angle,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IW-1:0]        rsp_id,
  output logic [SIZE-1:0]      rsp_x,
  output logic [SIZE-1:0]      rsp_y,
  output logic                 rsp_err,
  output logic                 cor_start,
  output logic [SIZE-1:0]      cor_xin,
  output logic [SIZE-1:0]      cor_yin,
  output logic [SIZE-1:0]      cor_angle,
  input  logic                 cor_done,
  input  logic [SIZE-1:0]      cor_xout,
  input  logic [SIZE-1:0]      cor_yout
);
  import cordic_pkg::*;

  sched_state_e    r_state, w_nxt;
  logic [IW-1:0]   r_ptr, r_gid, r_rsp_id;
  logic [SIZE-1:0] r_xin, r_yin, r_ang;
  logic [SIZE-1:0] r_rsp_x, r_rsp_y;
  logic [NREQ-1:0] w_grant;
  logic [IW-1:0]   w_idx;
  logic            w_any;
  logic            w_tmo;
  logic            w_acc;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_acc = (r_state == IDLE) && w_any;

`ifdef CORDIC_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] r_cnt;
  logic          r_err;

  assign w_tmo = (r_state == WAIT) && !cor_done &&
                 (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (r_state == WAIT) r_cnt <= r_cnt + 1'b1;
      else                 r_cnt <= '0;
      if (w_tmo)                       r_err <= 1'b1;
      else if (r_state == WAIT)        r_err <= 1'b0;
      else if (rsp_valid && rsp_ready) r_err <= 1'b0;
    end
  end

  assign rsp_err = r_err;
`else
  assign w_tmo   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_nxt = ISSUE;
      ISSUE:   w_nxt = WAIT;
      WAIT:    if (cor_done || w_tmo) w_nxt = RESP;
      RESP:    if (rsp_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nxt;
  end

  // Operands latch only at accept, so they hold through ISSUE and WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_gid    <= '0;
      r_xin    <= '0;
      r_yin    <= '0;
      r_ang    <= '0;
      r_rsp_id <= '0;
      r_rsp_x  <= '0;
      r_rsp_y  <= '0;
    end else begin
      if (w_acc) begin
        r_xin <= req_x[int'(w_idx)*SIZE +: SIZE];
        r_yin <= req_y[int'(w_idx)*SIZE +: SIZE];
        r_ang <= req_angle[int'(w_idx)*SIZE +: SIZE];
        r_gid <= w_idx;
        r_ptr <= (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;
      end
      if (r_state == WAIT && cor_done) begin
        r_rsp_x  <= cor_xout;
        r_rsp_y  <= cor_yout;
        r_rsp_id <= r_gid;
      end else if (w_tmo) begin
        r_rsp_x  <= '0;
        r_rsp_y  <= '0;
        r_rsp_id <= r_gid;
      end
    end
  end

  assign req_ready = (r_state == IDLE) ? w_grant : '0;
  assign cor_start = (r_state == ISSUE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_x     = r_rsp_x;
  assign rsp_y     = r_rsp_y;
  assign cor_xin   = r_xin;
  assign cor_yin   = r_yin;
  assign cor_angle = r_ang;
endmodule

// File: tb/tb_cordic_rr_sched.sv
// Bench for cordic_rr_sched with a fixed-latency stub engine.
// Round-robin order and results come from a behavioural model.
module tb_cordic_rr_sched;
  localparam int NREQ = 4;
  localparam int SIZE = 16;
  localparam int IW   = 2;
  localparam int LAT  = 12;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*SIZE-1:0] req_x, req_y, req_angle;
  logic                 rsp_valid, rsp_ready;
  logic [IW-1:0]        rsp_id;
  logic [SIZE-1:0]      rsp_x, rsp_y;
  logic                 rsp_err;
  logic                 cor_start, cor_done;
  logic [SIZE-1:0]      cor_xin, cor_yin, cor_angle;
  logic [SIZE-1:0]      cor_xout, cor_yout;

  cordic_rr_sched #(.NREQ(NREQ), .SIZE(SIZE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_angle (req_angle),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_x     (rsp_x),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err),
    .cor_start (cor_start),
    .cor_xin   (cor_xin),
    .cor_yin   (cor_yin),
    .cor_angle (cor_angle),
    .cor_done  (cor_done),
    .cor_xout  (cor_xout),
    .cor_yout  (cor_yout)
  );

  always #5 clk = ~clk;

  // Stub engine, deliberately not reset so stale completions can occur.
  logic            stub_busy = 1'b0;
  int              stub_cnt  = 0;
  logic [SIZE-1:0] stub_x    = '0;
  logic [SIZE-1:0] stub_y    = '0;

  always @(posedge clk) begin
    if (cor_start) begin
      stub_busy <= 1'b1;
      stub_cnt  <= LAT - 1;
      stub_x    <= cor_xin + cor_angle;
      stub_y    <= cor_yin - cor_angle;
    end else if (stub_busy) begin
      if (stub_cnt == 0) stub_busy <= 1'b0;
      else               stub_cnt  <= stub_cnt - 1;
    end
  end

  assign cor_done = stub_busy && (stub_cnt == 0);
  assign cor_xout = stub_x;
  assign cor_yout = stub_y;

  int n_assert = 0;
  int n_fail   = 0;

  logic [NREQ-1:0] vmask;
  logic [SIZE-1:0] ox [NREQ];
  logic [SIZE-1:0] oy [NREQ];
  logic [SIZE-1:0] oa [NREQ];
  int              mptr;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    req_valid = vmask;
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*SIZE +: SIZE]     = ox[i];
      req_y[i*SIZE +: SIZE]     = oy[i];
      req_angle[i*SIZE +: SIZE] = oa[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++) begin
      ox[i] = SIZE'($urandom);
      oy[i] = SIZE'($urandom);
      oa[i] = SIZE'($urandom);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++)
      if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic outs_zero(input string tag);
    chk(tag, {req_ready, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err,
              cor_start, cor_xin, cor_yin, cor_angle}, '0);
  endtask

  // Entered and left at negedge+1, with the DUT idle.
  task automatic run_op(input int rdelay, input bit drop);
    int acc, eg, st, nst, rv;
    logic [SIZE-1:0] ex, ey;
    logic [NREQ-1:0] eoh;
    apply();
    #1;
    acc = -1;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      if (|req_ready) begin acc = i; break; end
    end
    chk("accept_seen", acc >= 0, 1);
    if (acc < 0) return;
    eg  = rr_pick(vmask, mptr);
    eoh = '0;
    eoh[eg] = 1'b1;
    chk("grant", req_ready, eoh);
    ex   = ox[eg] + oa[eg];
    ey   = oy[eg] - oa[eg];
    mptr = (eg + 1) % NREQ;
    st = -1; nst = 0; rv = -1;
    for (int n = 1; n < 60; n++) begin
      @(negedge clk);
      #1;
      if (n == 1 && drop) begin vmask[eg] = 1'b0; apply(); #1; end
      if (cor_start) begin
        nst++;
        if (st < 0) begin
          st = n;
          chk("operands", {cor_xin, cor_yin, cor_angle},
              {ox[eg], oy[eg], oa[eg]});
        end
      end
      if (n == 2) chk("busy_ready", req_ready, '0);
      if (rsp_valid) begin rv = n; break; end
    end
    chk("start_cycle", st, 1);
    chk("start_count", nst, 1);
    chk("rsp_cycle", rv, LAT + 2);
    chk("rsp_data", {rsp_id, rsp_x, rsp_y, rsp_err},
        {IW'(eg), ex, ey, 1'b0});
    for (int d = 0; d < rdelay; d++) begin
      @(negedge clk);
      #1;
      chk("rsp_hold", {rsp_valid, req_ready, cor_start, rsp_id, rsp_x, rsp_y},
          {1'b1, 4'b0, 1'b0, IW'(eg), ex, ey});
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("rsp_drop", rsp_valid, 1'b0);
  endtask

  initial begin
    int bad, acc;
    rst_n     = 1'b0;
    rsp_ready = 1'b0;
    vmask     = '0;
    mptr      = 0;
    for (int i = 0; i < NREQ; i++) begin
      ox[i] = '0; oy[i] = '0; oa[i] = '0;
    end
    apply();
    repeat (3) @(negedge clk);
    #1;
    outs_zero("reset_vals");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_no_req", {req_ready, rsp_valid, cor_start}, '0);

    // Single request with known operands.
    ox[0] = 16'h1000; oy[0] = 16'h0000; oa[0] = 16'h0C90;
    vmask = 4'b0001;
    run_op(0, 1'b1);
    chk("t1_x", rsp_x, 16'h1C90);
    chk("t1_y", rsp_y, 16'hF370);

    // Reset while the engine is busy.
    rand_ops();
    vmask = 4'b0100;
    apply();
    #1;
    acc = -1;
    for (int i = 0; i < 30; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      if (|req_ready) begin acc = i; break; end
    end
    chk("t4_grant", req_ready, 4'b0100);
    @(negedge clk);
    vmask = '0;
    apply();
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    outs_zero("t4_reset_vals");
    repeat (2) @(negedge clk);
    #1;
    outs_zero("t4_reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    mptr  = 0;
    #1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (rsp_valid || cor_start || (req_ready != '0)) bad = 1;
    end
    chk("t4_stale_done", bad, 0);

    // All requesters held valid.
    vmask = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      rand_ops();
      run_op(0, 1'b0);
    end

    // Consumer stalls in RESP.
    rand_ops();
    run_op(20, 1'b0);

    // Random masks, operands and stalls.
    for (int k = 0; k < 24; k++) begin
      rand_ops();
      vmask = NREQ'($urandom_range(1, 15));
      run_op(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
